riscvlong_test_mem_responder: RTL
=================================

// Module: riscvlong_test_mem_responder
//
// PURPOSE
//  Responder end of the vc_MemReqMsg/vc_MemRespMsg port pair driven by the riscvlong core (imem or dmem).
//  Accepts 67-bit requests {type,addr[31:0],len[1:0],data[31:0]} via val/rdy.
//  Returns 35-bit responses {type,len[1:0],data[31:0]} via val only (core has no resp rdy).
//  Word-organised RAM, fixed pipelined latency, byte/half/word lanes, backdoor init port for benches.
//
// PARAMETERS
//  p_mem_words  1024  RAM depth in 32-bit words; power of two, >=2
//  p_latency    2     cycles from request fire to resp_val; 1..8
//  p_seed       8'hA5 LFSR seed, used only with RISCVLONG_MEMRESP_STALL_EN; must be nonzero
//
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  memreq_msg     in   67  request: [66]type(0 rd,1 wr) [65:34]addr [33:32]len [31:0]data
//  memreq_val     in   1   request valid
//  memreq_rdy     out  1   responder ready; fire = val & rdy
//  memresp_msg    out  35  response: [34]type [33:32]len [31:0]data
//  memresp_val    out  1   response valid, one cycle per fired request
//  init_en        in   1   backdoor word write, highest priority, ignores handshake
//  init_addr      in   32  backdoor byte address, word index = addr[idx+1:2]
//  init_data      in   32  backdoor write data
//
// BEHAVIOUR
//  - Reset: memresp_val=0, memresp_msg=0, memreq_rdy=0 while reset high. All in-flight pipeline slots cleared.
//    RAM contents are not reset and are preserved across reset.
//  - memreq_rdy=1 every cycle after reset deasserts (see CONFIGURATION).
//  - Index: idx = log2(p_mem_words); word = addr[idx+1:2]. Upper addr bits are ignored (address wraps modulo RAM size).
//  - len: 0=word, 1=byte, 2=half, 3=reserved (treated as word). Lane offset = addr[1:0] for byte, {addr[1],1'b0} for half.
//    Word ignores addr[1:0].
//  - Write fire: only the selected byte lanes of RAM[word] are updated at the firing edge, using data[7:0]/[15:0]/[31:0].
//    Response carries type=1, len echoed, data=0.
//  - Read fire: the RAM word is sampled at the firing edge, after any same-edge init write.
//    Selected lanes are shifted to bit 0 and zero-extended; the core sign-extends.
//    Response carries type=0, len echoed.
//  - Ordering: a write fired at edge n is visible to a read fired at edge n+1.
//  - Same edge init_en and write fire to the same word: the request write wins for its lanes; init writes the rest.
//  - Latency: shift pipeline of p_latency slots {val,msg}, advancing every cycle (no backpressure).
//    A request firing in cycle c yields memresp_val=1 in cycle c+p_latency, for exactly one cycle.
//    Back-to-back fires yield back-to-back responses in order; throughput is 1 per cycle.
//  - memresp_msg=0 whenever memresp_val=0.
//  - Reset asserted mid-flight drops all pending responses; no response appears after reset deasserts.
//
// CONFIGURATION
//  RISCVLONG_MEMRESP_STALL_EN defined:
//    - 8-bit Fibonacci LFSR (taps 8,6,5,4) resets to p_seed and advances every cycle.
//    - memreq_rdy = ~(lfsr[1:0]==2'b00), giving ~25% pseudo-random refusal. Response latency after fire is unchanged.
//  RISCVLONG_MEMRESP_STALL_EN undefined:
//    - No LFSR logic; memreq_rdy=1 whenever reset is low.
//
// TESTING
//  1. Reset: hold reset 3 cycles with memreq_val=1 -> memreq_rdy=0, memresp_val=0.
//     No response appears after release.
//  2. init 0x100<=0xDEADBEEF; word read 0x100 (p_latency=2) -> resp_val exactly 2 cycles later,
//     msg={0,2'd0,32'hDEADBEEF}.
//  3. Byte write 0x101 data 0x55, then byte read 0x101 -> 0x00000055; word read 0x100 -> 0xDEAD55EF.
//  4. Half read 0x102 after step 3 -> 0x0000DEAD.
//     10 back-to-back word reads -> 10 consecutive resp_val cycles, in order.
//  5. Address 0x100+4*p_mem_words reads the same word as 0x100.
//     Reset asserted with 2 responses in flight -> both dropped.
//  6. STALL_EN build: 200 cycles of random reads -> rdy low on some cycles.
//     Every fire gets exactly one response p_latency cycles later; data matches the scoreboard.

Source files
------------

// File: rtl/riscvlong_test_mem_responder.sv
// riscvlong_test_mem_responder
// Responder end of the riscvlong memory request/response port pair. It holds a
// word-organised RAM with byte/half/word lanes and answers every accepted
// request after a fixed pipelined latency. A backdoor init port lets a bench
// preload words.
// Optional feature: define RISCVLONG_MEMRESP_STALL_EN to refuse about 25% of
// cycles with an LFSR-driven memreq_rdy.
module riscvlong_test_mem_responder #(
    parameter int unsigned p_mem_words = 1024,
    parameter int unsigned p_latency   = 2,
    parameter logic [7:0]  p_seed      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [66:0] memreq_msg,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    output logic [34:0] memresp_msg,
    output logic        memresp_val,
    input  logic        init_en,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data
);

    localparam int unsigned IDX = $clog2(p_mem_words);

    typedef enum logic [1:0] {
        LEN_WORD = 2'd0,
        LEN_BYTE = 2'd1,
        LEN_HALF = 2'd2,
        LEN_RSVD = 2'd3
    } len_e;

    typedef struct packed {
        logic        val;
        logic [34:0] msg;
    } slot_t;

    // Request fields.
    logic           req_type;
    logic [31:0]    req_addr;
    len_e           req_len;
    logic [31:0]    req_data;
    logic [IDX-1:0] req_word;
    logic [IDX-1:0] init_word;

    assign req_type  = memreq_msg[66];
    assign req_addr  = memreq_msg[65:34];
    assign req_len   = len_e'(memreq_msg[33:32]);
    assign req_data  = memreq_msg[31:0];
    assign req_word  = req_addr[IDX+1:2];
    assign init_word = init_addr[IDX+1:2];

    logic fire;
    logic wr_fire;

    assign fire    = memreq_val & memreq_rdy;
    assign wr_fire = fire & req_type;

    // Upper address bits wrap away and the seed is only used by the stall build.
    logic unused_ok;
    assign unused_ok = ^{p_seed, req_addr[1:0], req_addr[31:IDX+2], init_addr};

    // RAM storage.
    logic [31:0] mem_q [p_mem_words];

    // Byte-lane enables and lane-replicated write data for a request write.
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_be   = 4'b1111;
        wr_data = req_data;
        case (req_len)
            LEN_BYTE: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_data[7:0]}};
            end
            LEN_HALF: begin
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_data[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = req_data;
            end
        endcase
    end

    // Init write first, request lanes second, so the request overrides its own lanes on a collision.
    // NOTE: RAM has no reset branch; contents survive reset and stay mappable to plain block RAM.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem_q[init_word] <= init_data;
        end
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[req_word][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // A read sees a same-edge init write to its word.
    logic [31:0] ram_word;
    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    assign ram_word   = (init_en && (init_word == req_word)) ? init_data : mem_q[req_word];
    assign byte_shift = ram_word >> {req_addr[1:0], 3'b000};
    assign half_shift = ram_word >> {req_addr[1], 4'b0000};

    // Move the selected lanes down to bit 0 and zero-extend.
    logic [31:0] rd_data;

    always_comb begin
        rd_data = ram_word;
        case (req_len)
            LEN_BYTE: rd_data = {24'h0, byte_shift[7:0]};
            LEN_HALF: rd_data = {16'h0, half_shift[15:0]};
            default:  rd_data = ram_word;
        endcase
    end

    // Build the response entering the first pipeline slot; an empty slot carries an all-zero message.
    slot_t slot0_d;

    always_comb begin
        slot0_d = '0;
        if (fire) begin
            slot0_d.val = 1'b1;
            slot0_d.msg = {req_type, memreq_msg[33:32], req_type ? 32'h0 : rd_data};
        end
    end

    // Fixed-latency response pipeline; reset flushes every in-flight slot.
    slot_t pipe_q [p_latency];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(p_latency); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every slot shift from its pre-edge value.
            pipe_q[0] <= slot0_d;
            for (int i = 1; i < int'(p_latency); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign memresp_val = pipe_q[p_latency-1].val;
    assign memresp_msg = pipe_q[p_latency-1].msg;

`ifdef RISCVLONG_MEMRESP_STALL_EN
    // Fibonacci LFSR, taps 8,6,5,4, stepping every cycle.
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Next LFSR state.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register, restarting from the seed on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= p_seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign memreq_rdy = ~reset & (lfsr_q[1:0] != 2'b00);
`else
    assign memreq_rdy = ~reset;
`endif

endmodule
